// File: rtl/mul_unit.sv
// Iterative RISC-V M-extension multiply unit: operand capture with ALU/LSU snooping,
// 32-step unsigned shift-add on magnitudes, sign fix-up, and writeback handshake.
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_load,
    input  logic [1:0]      mul_funct,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [1:0]      data1_depend,
    input  logic [1:0]      data2_depend,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            alu_done,
    input  logic [4:0]      rd_alu_update,
    input  logic [XLEN-1:0] alu_result,
    input  logic            lsu_done,
    input  logic [4:0]      rd_lsu_update,
    input  logic [XLEN-1:0] lsu_result,
    input  logic            wb_grant,
    output logic [1:0]      mul_state,
    output logic            mul_done,
    output logic [4:0]      rd_mul_update,
    output logic [XLEN-1:0] mul_result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10,
        S_WAIT = 2'b11
    } state_t;

    state_t              state_q;
    logic [1:0]          funct_q;
    logic [4:0]          rd_q;
    logic [4:0]          rs_q     [2];
    logic [1:0]          dep_q    [2];
    logic [XLEN-1:0]     op_q     [2];
    logic [1:0]          pend_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic                neg_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     result_q;
    logic [XLEN-1:0]     last_q;

    logic                is_load;
    logic                is_wait;
    logic                start_busy;
    logic [1:0]          funct_d;
    logic [1:0]          signed_op;
    logic [1:0]          neg_op;
    logic [1:0]          pend_d;
    logic [XLEN-1:0]     op_d     [2];
    logic [XLEN-1:0]     mag      [2];
    logic [1:0]          dep_in   [2];
    logic [4:0]          rs_in    [2];
    logic [XLEN-1:0]     rf_in    [2];
    logic [2*XLEN-1:0]   addend;
    logic [2*XLEN-1:0]   acc_sum;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     prod_sel;

    // Returns {pending, value} for one operand given its producer code.
    function automatic logic [XLEN:0] resolve(
        input logic [1:0]      dep,
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf,
        input logic            pend,
        input logic [XLEN-1:0] held,
        input logic            load,
        input logic            waiting
    );
        logic alu_hit;
        logic lsu_hit;
        alu_hit = alu_done && (rd_alu_update == rs);
        lsu_hit = lsu_done && (rd_lsu_update == rs);
        resolve = {pend, held};
        if (load) begin
            case (dep)
                2'b00:   resolve = {1'b0, rf};
                2'b10:   resolve = {1'b0, last_q};
                2'b01:   resolve = alu_hit ? {1'b0, alu_result} : {1'b1, held};
                default: resolve = lsu_hit ? {1'b0, lsu_result} : {1'b1, held};
            endcase
        end else if (waiting && pend) begin
            if (dep == 2'b01 && alu_hit) begin
                resolve = {1'b0, alu_result};
            end else if (dep == 2'b11 && lsu_hit) begin
                resolve = {1'b0, lsu_result};
            end
        end
    endfunction

    assign is_load      = (state_q == S_IDLE) && mul_load;
    assign is_wait      = (state_q == S_WAIT);
    assign funct_d      = is_load ? mul_funct : funct_q;
    assign signed_op[0] = (funct_d != 2'b11);
    assign signed_op[1] = (funct_d[1] == 1'b0);

    assign dep_in[0] = data1_depend;
    assign dep_in[1] = data2_depend;
    assign rs_in[0]  = rs1;
    assign rs_in[1]  = rs2;
    assign rf_in[0]  = rs1_data;
    assign rf_in[1]  = rs2_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            assign {pend_d[gi], op_d[gi]} = resolve(
                is_load ? dep_in[gi] : dep_q[gi],
                is_load ? rs_in[gi]  : rs_q[gi],
                rf_in[gi], pend_q[gi], op_q[gi], is_load, is_wait);
            // 0x80000000 negates to itself, which read unsigned is the 2^31 magnitude.
            assign neg_op[gi] = signed_op[gi] & op_d[gi][XLEN-1];
            assign mag[gi]    = neg_op[gi] ? (~op_d[gi] + 1'b1) : op_d[gi];
        end
    endgenerate

    assign start_busy = (is_load || is_wait) && (pend_d == 2'b00);

    assign addend   = mplier_q[0] ? mcand_q : '0;
    assign acc_sum  = acc_q + addend;
    assign prod     = neg_q ? (~acc_sum + 1'b1) : acc_sum;
    assign prod_sel = (funct_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct_q  <= '0;
            rd_q     <= '0;
            pend_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            last_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                rs_q[i]  <= '0;
                dep_q[i] <= '0;
                op_q[i]  <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int i = 0; i < 2; i++) begin
                op_q[i] <= op_d[i];
            end
            if (start_busy) begin
                acc_q    <= '0;
                mcand_q  <= {{XLEN{1'b0}}, mag[0]};
                mplier_q <= mag[1];
                neg_q    <= neg_op[0] ^ neg_op[1];
                cnt_q    <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (mul_load) begin
                        funct_q  <= mul_funct;
                        rd_q     <= rd;
                        rs_q[0]  <= rs1;
                        rs_q[1]  <= rs2;
                        dep_q[0] <= data1_depend;
                        dep_q[1] <= data2_depend;
                        state_q  <= start_busy ? S_BUSY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (start_busy) begin
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_q    <= acc_sum;
                    mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        result_q <= prod_sel;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    if (wb_grant) begin
                        last_q  <= result_q;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign mul_state     = state_q;
    assign mul_done      = rst_n & wb_grant & (state_q == S_DONE);
    assign rd_mul_update = rd_q;
    assign mul_result    = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus randomized operations
// compared against a wide-arithmetic reference of the M-extension multiply rules.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_load;
    logic [1:0]  mul_funct;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  data1_depend, data2_depend;
    logic [31:0] rs1_data, rs2_data;
    logic        alu_done;
    logic [4:0]  rd_alu_update;
    logic [31:0] alu_result;
    logic        lsu_done;
    logic [4:0]  rd_lsu_update;
    logic [31:0] lsu_result;
    logic        wb_grant;
    logic [1:0]  mul_state;
    logic        mul_done;
    logic [4:0]  rd_mul_update;
    logic [31:0] mul_result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    mul_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .mul_load(mul_load), .mul_funct(mul_funct),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .data1_depend(data1_depend), .data2_depend(data2_depend),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_done(alu_done), .rd_alu_update(rd_alu_update), .alu_result(alu_result),
        .lsu_done(lsu_done), .rd_lsu_update(rd_lsu_update), .lsu_result(lsu_result),
        .wb_grant(wb_grant), .mul_state(mul_state), .mul_done(mul_done),
        .rd_mul_update(rd_mul_update), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Reference: extend each operand per funct signedness, multiply wide, pick a word.
    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [65:0] x, y, p;
        x = {{34{(f != 2'b11) & a[31]}}, a};
        y = {{34{(f[1] == 1'b0) & b[31]}}, b};
        p = x * y;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        alu_done = 1'b0; lsu_done = 1'b0;
        rd_alu_update = 5'd0; rd_lsu_update = 5'd0;
        alu_result = $urandom(); lsu_result = $urandom();
    endtask

    task automatic decoy(input logic [4:0] r1, input logic [4:0] r2);
        alu_done = 1'b1; rd_alu_update = r1 ^ 5'd1; alu_result = $urandom();
        lsu_done = 1'b1; rd_lsu_update = r2 ^ 5'd1; lsu_result = $urandom();
    endtask

    task automatic fire(input logic [4:0] r1, input logic [4:0] r2, input logic [1:0] d1,
                        input logic [1:0] d2, input logic [31:0] v1, input logic [31:0] v2);
        clear_bus();
        if (d1 == 2'b01) begin alu_done = 1'b1; rd_alu_update = r1; alu_result = v1; end
        if (d2 == 2'b11) begin lsu_done = 1'b1; rd_lsu_update = r2; lsu_result = v2; end
    endtask

    // One instruction from issue to writeback; fwd = cycles until pending operands arrive.
    task automatic run_op(input string tag, input logic [1:0] f, input logic [4:0] rdv,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [1:0] d1, input logic [1:0] d2,
                          input logic [31:0] v1, input logic [31:0] v2,
                          input int fwd, input int stall);
        logic [31:0] exp;
        logic [31:0] e1, e2;
        int n, early;
        bit pending;
        e1  = (d1 == 2'b10) ? last_res : v1;
        e2  = (d2 == 2'b10) ? last_res : v2;
        exp = ref_mul(f, e1, e2);
        pending = ((d1 == 2'b01) || (d2 == 2'b11)) && (fwd > 0);
        wb_grant = (stall == 0);
        mul_load = 1'b1; mul_funct = f; rd = rdv; rs1 = r1; rs2 = r2;
        data1_depend = d1; data2_depend = d2;
        rs1_data = (d1 == 2'b00) ? v1 : $urandom();
        rs2_data = (d2 == 2'b00) ? v2 : $urandom();
        if (fwd == 0) fire(r1, r2, d1, d2, v1, v2);
        else decoy(r1, r2);
        cyc();
        mul_load = 1'b0; mul_funct = $urandom(); rd = $urandom();
        rs1 = $urandom(); rs2 = $urandom();
        data1_depend = $urandom(); data2_depend = $urandom();
        rs1_data = $urandom(); rs2_data = $urandom();
        clear_bus();
        if (pending) begin
            for (int k = 1; k <= fwd; k++) begin
                chk({tag, "/wait_state"}, 32'(mul_state), 32'h3);
                if (k == fwd) fire(r1, r2, d1, d2, v1, v2);
                else decoy(r1, r2);
                cyc();
                clear_bus();
            end
        end
        chk({tag, "/busy_entry"}, 32'(mul_state), 32'h1);
        n = 0; early = 0;
        while (mul_state !== 2'b10 && n < 100) begin
            if (mul_done !== 1'b0) early++;
            cyc();
            n++;
        end
        chk({tag, "/busy_len"}, 32'(n), 32'd32);
        chk({tag, "/no_early_done"}, 32'(early), 32'd0);
        chk({tag, "/result"}, mul_result, exp);
        chk({tag, "/rd"}, 32'(rd_mul_update), 32'(rdv));
        for (int k = 0; k < stall; k++) begin
            chk({tag, "/stall_state"}, 32'(mul_state), 32'h2);
            chk({tag, "/stall_done"}, 32'(mul_done), 32'h0);
            chk({tag, "/stall_result"}, mul_result, exp);
            cyc();
        end
        wb_grant = 1'b1;
        #1;
        chk({tag, "/done_pulse"}, 32'(mul_done), 32'h1);
        chk({tag, "/done_state"}, 32'(mul_state), 32'h2);
        cyc();
        wb_grant = 1'b0;
        chk({tag, "/idle_after"}, 32'(mul_state), 32'h0);
        chk({tag, "/done_low"}, 32'(mul_done), 32'h0);
        last_res = exp;
        $display("op %s funct=%0d a=%08h b=%08h -> %08h (busy %0d cycles)",
                 tag, f, e1, e2, mul_result, n);
    endtask

    initial begin
        int n, dones;
        logic [1:0]  f, d1, d2;
        logic [31:0] a, b;
        rst_n = 1'b0; mul_load = 1'b0; mul_funct = '0; rd = '0; rs1 = '0; rs2 = '0;
        data1_depend = '0; data2_depend = '0; rs1_data = '0; rs2_data = '0;
        wb_grant = 1'b0;
        clear_bus();
        cyc(); cyc();
        chk("reset/state", 32'(mul_state), 32'h0);
        chk("reset/done", 32'(mul_done), 32'h0);
        chk("reset/rd", 32'(rd_mul_update), 32'h0);
        chk("reset/result", mul_result, 32'h0);
        rst_n = 1'b1;
        cyc();

        run_op("mul_7x6", 2'b00, 5'd9, 5'd1, 5'd2, 2'b00, 2'b00, 32'd7, 32'd6, 0, 0);
        run_op("mulh_min", 2'b01, 5'd10, 5'd3, 5'd4, 2'b00, 2'b00,
               32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op("mulhu_max", 2'b11, 5'd11, 5'd3, 5'd4, 2'b00, 2'b00,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op("mulhsu_m1x2", 2'b10, 5'd12, 5'd3, 5'd4, 2'b00, 2'b00,
               32'hFFFF_FFFF, 32'd2, 0, 0);
        run_op("mul_m3x5", 2'b00, 5'd0, 5'd3, 5'd4, 2'b00, 2'b00,
               32'hFFFF_FFFD, 32'd5, 0, 0);
        run_op("alu_wait4", 2'b00, 5'd13, 5'd5, 5'd6, 2'b01, 2'b00, 32'd9, 32'd11, 4, 0);
        run_op("lsu_fwd0", 2'b00, 5'd14, 5'd7, 5'd3, 2'b00, 2'b11, 32'd25, 32'd4, 0, 0);
        run_op("both_wait", 2'b01, 5'd15, 5'd8, 5'd9, 2'b01, 2'b11,
               32'hDEAD_BEEF, 32'h8765_4321, 2, 0);
        run_op("stall10", 2'b11, 5'd16, 5'd1, 5'd2, 2'b00, 2'b00,
               32'h1234_5678, 32'h9ABC_DEF0, 0, 10);
        run_op("last_fwd", 2'b00, 5'd17, 5'd1, 5'd2, 2'b10, 2'b00, 32'd0, 32'd3, 0, 0);

        // Abort mid-BUSY: reset wins and the instruction never completes.
        wb_grant = 1'b1;
        mul_load = 1'b1; mul_funct = 2'b00; rd = 5'd20; rs1 = 5'd1; rs2 = 5'd2;
        data1_depend = 2'b00; data2_depend = 2'b00; rs1_data = 32'd123; rs2_data = 32'd456;
        cyc();
        mul_load = 1'b0;
        for (int k = 0; k < 15; k++) cyc();
        chk("abort/busy", 32'(mul_state), 32'h1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("abort/state", 32'(mul_state), 32'h0);
        chk("abort/done", 32'(mul_done), 32'h0);
        chk("abort/rd", 32'(rd_mul_update), 32'h0);
        chk("abort/result", mul_result, 32'h0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (mul_done !== 1'b0 || mul_state !== 2'b00) dones++;
            cyc();
        end
        chk("abort/no_done", 32'(dones), 32'd0);
        wb_grant = 1'b0;
        last_res = '0;
        run_op("last_after_rst", 2'b00, 5'd21, 5'd1, 5'd2, 2'b00, 2'b10, 32'd77, 32'd0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            f = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = $urandom_range(0, 15);
                default: a = $urandom();
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(0, 15);
                default: b = $urandom();
            endcase
            d1 = (i < 3) ? 2'b00 : 2'($urandom_range(0, 2));
            d2 = 2'($urandom_range(0, 2));
            if (d2 == 2'b01) d2 = 2'b11;
            n = $urandom_range(0, 5);
            run_op($sformatf("rnd%0d", i), f, 5'($urandom()), 5'($urandom_range(1, 31)),
                   5'($urandom_range(1, 31)), d1, d2, a, b, n, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative multiply functional unit that sits directly downstream of the scoreboard's issue logic. It accepts an issued RISC-V M-extension multiply (MUL/MULH/MULHSU/MULHU) when the scoreboard raises `mul_load`. It resolves pending source operands by snooping the ALU and LSU completion buses, then computes the product with a 32-step shift-add engine. It returns the result through a writeback handshake, and drives `mul_state`, `mul_done` and `rd_mul_update` back to the scoreboard so that the destination register's busy status is cleared.

## Interface
Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- mul_load  in  1  issue strobe from scoreboard; only honoured in IDLE
- mul_funct  in  2  00 MUL (low word), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- rd  in  5  destination register of the issued instruction
- rs1, rs2  in  5  source register indices
- data1_depend, data2_depend  in  2  producer code per source: 00 ready, 01 ALU, 10 MUL, 11 LSU
- rs1_data, rs2_data  in  XLEN  register-file read data, valid when the depend code is 00
- alu_done  in  1  ALU completion
- rd_alu_update  in  5  ALU destination
- alu_result  in  XLEN  ALU result
- lsu_done  in  1  LSU completion
- rd_lsu_update  in  5  LSU destination
- lsu_result  in  XLEN  LSU result
- wb_grant  in  1  writeback port accepts the result this cycle
- mul_state  out  2  00 IDLE, 11 WAIT, 01 BUSY, 10 DONE
- mul_done  out  1  result transferred; equals (state==DONE) & wb_grant
- rd_mul_update  out  5  captured rd; held from load until leaving DONE
- mul_result  out  XLEN  result; stable throughout DONE

## Operation
- IDLE + mul_load: latch funct, rd, rs1, rs2, and both depend codes.
- Per-operand capture at load:
  - code 00: latch the rs data.
  - code 10: latch the internal last-result register.
  - code 01/11: mark the operand pending.
- Same-cycle forwarding: if the producer's done fires in the load cycle and its rd matches, capture from the bus immediately.
- Next state from IDLE: WAIT if any operand is still pending, else BUSY.
- WAIT: each cycle, a pending operand with code 01 captures alu_result when alu_done & rd_alu_update==rs. Code 11 captures lsu_result the same way on lsu_done. WAIT→BUSY on the cycle after the last operand is captured. Both operands may be captured in the same cycle.
- BUSY: the signedness of each operand comes from funct.
  - Convert each operand to magnitude and record result sign = s1 ^ s2.
  - Unsigned shift-add over 32 steps, one multiplier bit per cycle, with a 64-bit accumulator.
  - Step counter counts 0..31; after step 31, negate the 64-bit product if the result sign is set.
  - Select the low word for MUL, the high word otherwise, then go to DONE.
- Last-result register: updated with mul_result on mul_done.
- DONE: hold mul_result and rd_mul_update. On wb_grant, assert mul_done for one cycle and return to IDLE.
- mul_load outside IDLE is ignored; the scoreboard never issues then.
- rd = x0 is processed normally; writeback discards it.
- Arithmetic edge cases:
  - Magnitude of 0x80000000 is 2^31, held in 32 unsigned bits.
  - Product of two 2^31 magnitudes is 2^62, with no overflow in 64 bits.

## Timing
- Reset (rst_n low at a clk edge) values: state IDLE, mul_state 00, mul_done 0, rd_mul_update 0, mul_result 0, counter 0, pending flags 0, last-result register 0.
- Reset mid-operation aborts the instruction with no mul_done. Reset has priority over every other event.
- Latency with both operands ready, load at cycle T:
  - BUSY during T+1..T+32.
  - DONE at T+33.
  - mul_done no earlier than T+33, in the same cycle wb_grant is seen.
- A WAIT phase adds (capture cycle − T) cycles.
- mul_done high for exactly one cycle; mul_state reads 10 in that same cycle; IDLE the next cycle.
- A new mul_load is accepted in the cycle after mul_done.
- mul_result changes only on BUSY→DONE and is stable while wb_grant stays low.

## Test plan
- Ready operands: MUL 7×6 loaded at T → mul_state 10 at T+33, with wb_grant held 1 → mul_result 42, mul_done pulses at T+33, rd_mul_update = rd.
- Signed corners: MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF(−1)×2 → 0xFFFFFFFF. MUL −3×5 → 0xFFFFFFF1.
- Operand wait: data1_depend 01 on rs1=5. alu_done with rd_alu_update=5 and alu_result=9 arrives 4 cycles after load → WAIT for those cycles, then BUSY; 9×rs2 is correct.
- Same-cycle forward: data2_depend 11 on rs2=3, with lsu_done, rd_lsu_update=3, lsu_result=4 in the load cycle → no WAIT; BUSY at T+1.
- Writeback stall: hold wb_grant 0 for 10 cycles in DONE → mul_state stays 10, mul_result stable, mul_done 0; a grant pulse → one mul_done, IDLE next cycle.
- Reset mid-BUSY: rst_n low at step 15 → next cycle all outputs are reset values; no mul_done is ever seen for the aborted instruction.
